tt_um_logic_counter: RTL and testbench

- Second-generation Tiny Tapeout user design: a selectable two-input logic gate with synchronised inputs and a debounced, registered output.
- Adds a rising-edge event counter on the gate output, exposed on the bidirectional pins driven as outputs.
- Sits directly under the Tiny Tapeout harness as the user top level.
- Pins: ui[0]=A, ui[1]=B, uo[0]=OUT.

---
 rtl/tt_logic_pkg.sv | 48 ++++
 rtl/tt_um_logic_counter_debounce_filter.sv | 51 +++++
 rtl/tt_um_logic_counter.sv | 131 +++++++++++++
 tb/tb_tt_um_logic_counter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_logic_pkg.sv
// Shared definitions for the tt_um_logic_counter design: gate function
// encoding, pin-index constants and the gate evaluation helper.
package tt_logic_pkg;

  // Gate selected by ui_in[4:2].
  typedef enum logic [2:0] {
    FN_AND  = 3'd0,
    FN_OR   = 3'd1,
    FN_XOR  = 3'd2,
    FN_NAND = 3'd3,
    FN_NOR  = 3'd4,
    FN_XNOR = 3'd5,
    FN_A    = 3'd6,
    FN_B    = 3'd7
  } func_e;

  // ui_in bit positions
  localparam int unsigned PIN_A        = 0;
  localparam int unsigned PIN_B        = 1;
  localparam int unsigned PIN_FUNC_LSB = 2;
  localparam int unsigned PIN_CLR      = 5;
  localparam int unsigned PIN_HOLD     = 6;

  // uo_out bit positions
  localparam int unsigned PIN_OUT  = 0;
  localparam int unsigned PIN_RISE = 1;
  localparam int unsigned PIN_OVF  = 2;

  // Debounce counter width; wide enough for the largest legal DEBOUNCE_CYCLES (15).
  localparam int unsigned DCNT_W = 4;

  function automatic logic gate_eval(input func_e func, input logic a, input logic b);
    logic res;
    case (func)
      FN_AND:  res = a & b;
      FN_OR:   res = a | b;
      FN_XOR:  res = a ^ b;
      FN_NAND: res = ~(a & b);
      FN_NOR:  res = ~(a | b);
      FN_XNOR: res = ~(a ^ b);
      FN_A:    res = a;
      FN_B:    res = b;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tt_um_logic_counter_debounce_filter.sv
// debounce_filter: passes din to dout only after din has disagreed with dout
// for DEBOUNCE_CYCLES consecutive enabled cycles. Shorter glitches are dropped.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (dout and count cleared)
//   en    - clock enable; 0 holds all state
//   din   - raw input
//   dout  - filtered, registered output
module debounce_filter
  import tt_logic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);

  localparam logic [DCNT_W-1:0] LastCnt = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              dout_q, dout_d;

  always_comb begin
    dcnt_d = dcnt_q;
    dout_d = dout_q;
    if (din == dout_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == LastCnt) begin
      dout_d = din;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
      dout_q <= 1'b0;
    end else if (en) begin
      dcnt_q <= dcnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/tt_um_logic_counter.sv
// tt_um_logic_counter: selectable two-input gate with synchronised inputs, a
// debounced registered output and an edge event counter on the uio pins.
// Optional build macro TT_LOGIC_BOTH_EDGES_EN: count both OUT transitions
// instead of rising edges only.
// Ports:
//   clk, rst_n, ena - clock, async active-low reset, global enable
//   ui_in           - [0]=A [1]=B [4:2]=FUNC [5]=CLR [6]=HOLD
//   uo_out          - [0]=OUT [1]=RISE pulse [2]=OVF sticky, rest 0
//   uio_in          - unused
//   uio_out         - event count in [CNT_W-1:0], rest 0
//   uio_oe          - all ones
module tt_um_logic_counter
  import tt_logic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Input synchronisers: stage SYNC_STAGES-1 is the only copy the logic sees.
  logic [SYNC_STAGES-1:0][6:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (ena) begin
      sync_q[0] <= ui_in[6:0];
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic [6:0] s_in;
  logic       s_a, s_b, s_clr, s_hold;
  func_e      s_func;

  assign s_in   = sync_q[SYNC_STAGES-1];
  assign s_a    = s_in[PIN_A];
  assign s_b    = s_in[PIN_B];
  assign s_func = func_e'(s_in[PIN_FUNC_LSB +: 3]);
  assign s_clr  = s_in[PIN_CLR];
  assign s_hold = s_in[PIN_HOLD];

  logic raw, out;

  assign raw = gate_eval(s_func, s_a, s_b);

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ena),
    .din  (raw),
    .dout (out)
  );

  // Edge detection against the previous OUT; RISE and the count update land
  // one cycle after OUT changes.
  logic             out_prev_q, rise_q, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_evt;

`ifdef TT_LOGIC_BOTH_EDGES_EN
  assign edge_evt = out ^ out_prev_q;
`else
  assign edge_evt = out & ~out_prev_q;
`endif

  localparam logic [CNT_W-1:0] CntMax = '1;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (s_clr) begin
      // CLR wins over any coincident edge
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (!s_hold && edge_evt) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (ena) begin
      out_prev_q <= out;
      rise_q     <= edge_evt;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  logic [7:0] cnt_ext;

  always_comb begin
    cnt_ext            = '0;
    cnt_ext[CNT_W-1:0] = cnt_q;
  end

  always_comb begin
    uo_out           = '0;
    uo_out[PIN_OUT]  = out;
    uo_out[PIN_RISE] = rise_q;
    uo_out[PIN_OVF]  = ovf_q;
  end

  assign uio_out = cnt_ext;
  assign uio_oe  = 8'hFF;

  logic unused_in;
  assign unused_in = ^{uio_in, ui_in[7]};

endmodule

// File: tb/tb_tt_um_logic_counter.sv
module tb_tt_um_logic_counter;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CW   = 8;
  localparam int LAT  = SYNC + DEB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_pass   = 0;

  tt_um_logic_counter #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference model: synchronised view is the ui_in value seen SYNC enabled
  // edges ago; OUT follows raw once it has disagreed for DEB edges in a row.
  logic [6:0] hist[$];
  logic       m_out, m_prev, m_rise, m_ovf;
  int         m_run, m_cnt;

  // Truth tables, 4 bits per FUNC, indexed by {a,b}.
  function automatic logic truth(input logic [2:0] f, input logic a, input logic b);
    logic [31:0] tbl;
    tbl = 32'hAC9176E8;
    return tbl[{f, a, b}];
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < SYNC; i++) hist.push_back(7'd0);
    m_out = 0; m_prev = 0; m_rise = 0; m_ovf = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [6:0] s;
    logic       raw, ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ena) return;
    s   = hist[SYNC-1];
    raw = truth(s[4:2], s[0], s[1]);
`ifdef TT_LOGIC_BOTH_EDGES_EN
    ev = (m_out != m_prev);
`else
    ev = m_out && !m_prev;
`endif
    if (s[5]) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (!s[6] && ev) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == (1 << CW)) begin
        m_cnt = 0;
        m_ovf = 1;
      end
    end
    m_rise = ev;
    m_prev = m_out;
    if (raw == m_out) begin
      m_run = 0;
    end else begin
      m_run = m_run + 1;
      if (m_run == DEB) begin
        m_out = raw;
        m_run = 0;
      end
    end
    hist.push_front(ui_in[6:0]);
    void'(hist.pop_back());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("uo_out", {24'd0, uo_out}, {29'd0, m_ovf, m_rise, m_out});
    check("uio_out", {24'd0, uio_out}, 32'(m_cnt & ((1 << CW) - 1)));
    check("uio_oe", {24'd0, uio_oe}, 32'hFF);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input logic [2:0] f, input logic a, input logic b,
                        input logic clr, input logic hold);
    ui_in = {1'b0, hold, clr, f, b, a};
  endtask

  typedef struct {
    logic [2:0] func;
    logic       a;
    logic       b;
    logic       exp_out;
  } gate_vec_t;

  gate_vec_t vecs[8];

  initial begin
    logic prev;
    int   pulses;

    for (int f = 0; f < 8; f++) begin
      vecs[f].func = 3'(f);
      vecs[f].a    = 1'b1;
      vecs[f].b    = 1'b0;
    end
    vecs[0].exp_out = 0; vecs[1].exp_out = 1; vecs[2].exp_out = 1; vecs[3].exp_out = 1;
    vecs[4].exp_out = 0; vecs[5].exp_out = 0; vecs[6].exp_out = 1; vecs[7].exp_out = 0;

    // Reset with random inputs
    rst_n  = 0;
    ena    = 1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    model_reset();
    #1;
    check("rst_uo", {24'd0, uo_out}, 32'h00);
    check("rst_uio", {24'd0, uio_out}, 32'h00);
    check("rst_oe", {24'd0, uio_oe}, 32'hFF);
    cycles(3);
    ui_in = 8'd0;
    #3 rst_n = 1;
    cycles(10);
    check("post_rst_uo", {24'd0, uo_out}, 32'h00);

    // Gate table with exact latency
    prev = 0;
    for (int v = 0; v < 8; v++) begin
      set_in(vecs[v].func, vecs[v].a, vecs[v].b, 0, 0);
      for (int k = 1; k <= LAT + 2; k++) begin
        cyc();
        if (k == LAT - 1) check("gate_pre", {31'd0, uo_out[0]}, {31'd0, prev});
        if (k == LAT) check("gate_out", {31'd0, uo_out[0]}, {31'd0, vecs[v].exp_out});
      end
      prev = vecs[v].exp_out;
    end
    check("gate_count", {24'd0, uio_out}, 32'd2);

    // Debounce: 3-cycle glitch rejected, 4+ cycles accepted
    set_in(3'd0, 1, 0, 0, 0);
    cycles(8);
    set_in(3'd0, 1, 1, 0, 0);
    cycles(3);
    set_in(3'd0, 1, 0, 0, 0);
    cycles(12);
    check("glitch_out", {31'd0, uo_out[0]}, 32'd0);
    check("glitch_cnt", {24'd0, uio_out}, 32'd2);
    set_in(3'd0, 1, 1, 0, 0);
    cycles(LAT);
    check("deb_out", {31'd0, uo_out[0]}, 32'd1);
    cyc();
    check("deb_rise", {31'd0, uo_out[1]}, 32'd1);
    cyc();
    check("deb_rise_end", {31'd0, uo_out[1]}, 32'd0);
    check("deb_cnt", {24'd0, uio_out}, 32'd3);

    // Clear, then 256 rises to wrap
    set_in(3'd0, 0, 1, 1, 0);
    cyc();
    set_in(3'd0, 0, 1, 0, 0);
    cycles(8);
    check("clr_cnt", {24'd0, uio_out}, 32'd0);
    for (int t = 0; t < 256; t++) begin
      set_in(3'd0, 1, 1, 0, 0);
      cycles(8);
      set_in(3'd0, 0, 1, 0, 0);
      cycles(8);
    end
    check("wrap_cnt", {24'd0, uio_out}, 32'd0);
    check("wrap_ovf", {31'd0, uo_out[2]}, 32'd1);
    set_in(3'd0, 0, 1, 1, 0);
    cyc();
    set_in(3'd0, 0, 1, 0, 0);
    cycles(4);
    check("ovf_clr_cnt", {24'd0, uio_out}, 32'd0);
    check("ovf_clr_ovf", {31'd0, uo_out[2]}, 32'd0);

    // HOLD: two normal rises, then three held rises
    for (int t = 0; t < 2; t++) begin
      set_in(3'd0, 1, 1, 0, 0);
      cycles(8);
      set_in(3'd0, 0, 1, 0, 0);
      cycles(8);
    end
    set_in(3'd0, 0, 1, 0, 1);
    cycles(4);
    pulses = 0;
    for (int t = 0; t < 3; t++) begin
      set_in(3'd0, 1, 1, 0, 1);
      for (int k = 0; k < 8; k++) begin
        cyc();
        if (uo_out[1]) pulses++;
      end
      set_in(3'd0, 0, 1, 0, 1);
      for (int k = 0; k < 8; k++) begin
        cyc();
        if (uo_out[1]) pulses++;
      end
    end
    check("hold_cnt", {24'd0, uio_out}, 32'd2);
`ifdef TT_LOGIC_BOTH_EDGES_EN
    check("hold_pulses", 32'(pulses), 32'd6);
`else
    check("hold_pulses", 32'(pulses), 32'd3);
`endif
    set_in(3'd0, 0, 1, 0, 0);
    cycles(4);

    // CLR landing on the same edge as the count update
    set_in(3'd0, 1, 1, 0, 0);
    cycles(4);
    set_in(3'd0, 1, 1, 1, 0);
    cyc();
    set_in(3'd0, 1, 1, 0, 0);
    cycles(6);
    check("clr_coinc_cnt", {24'd0, uio_out}, 32'd0);
    set_in(3'd0, 0, 1, 0, 0);
    cycles(8);

    // ena=0 freezes a pending toggle
    ena = 0;
    set_in(3'd0, 1, 1, 0, 0);
    cycles(20);
    check("ena_out", {31'd0, uo_out[0]}, 32'd0);
    ena = 1;
    cycles(LAT);
    check("ena_resume", {31'd0, uo_out[0]}, 32'd1);
    cyc();
`ifdef TT_LOGIC_BOTH_EDGES_EN
    check("ena_cnt", {24'd0, uio_out}, 32'd2);
`else
    check("ena_cnt", {24'd0, uio_out}, 32'd1);
`endif
    set_in(3'd0, 0, 1, 0, 0);
    cycles(8);

    // Async reset in the middle of a pending 0->1
    set_in(3'd0, 1, 1, 0, 0);
    cycles(3);
    #3 rst_n = 0;
    #1;
    model_reset();
    check("arst_uo", {24'd0, uo_out}, 32'h00);
    check("arst_uio", {24'd0, uio_out}, 32'h00);
    cyc();
    #3 rst_n = 1;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      if (k < LAT) check("arst_hold0", {31'd0, uo_out[0]}, 32'd0);
      else check("arst_out", {31'd0, uo_out[0]}, 32'd1);
    end

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        ui_in[4:0] = 5'($urandom);
        ui_in[5]   = ($urandom_range(0, 15) == 0);
        ui_in[6]   = ($urandom_range(0, 7) == 0);
        ui_in[7]   = 1'($urandom);
        uio_in     = 8'($urandom);
      end
      ena = ($urandom_range(0, 9) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
